// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction queue between fetch and the dual-issue decode stage.
//   Fetch pushes up to two {pc, instr} pairs per cycle; decode sees the two
//   oldest entries combinationally and pops 0, 1 or 2 of them per cycle.
//   Invalid read slots read as all-zero (instr 0 is a NOP to decode).
//
// Optional feature (macro INST_FETCH_QUEUE_EXCP_EN):
//   When defined, every entry also carries a 1-bit fetch address-error tag
//   (wr_adel0/1 in, rd_adel0/1 out). Tags are cleared by rst and flush.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop all entries (mispredict / exception / eret)
//   wr_en[1:0]        per-slot write valid (00, 01, 11 legal)
//   wr_pc0/1, wr_instr0/1   write slot data, slot 0 is older
//   almost_full       fewer than 2 free entries
//   empty             no entries
//   rd_num[1:0]       entries consumed by decode this cycle
//   rd_valid0/1, rd_pc0/1, rd_instr0/1   head and head+1 view
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [1:0]  wr_en,
   input  logic [31:0] wr_pc0,
   input  logic [31:0] wr_instr0,
   input  logic [31:0] wr_pc1,
   input  logic [31:0] wr_instr1,
`ifdef INST_FETCH_QUEUE_EXCP_EN
   input  logic        wr_adel0,
   input  logic        wr_adel1,
   output logic        rd_adel0,
   output logic        rd_adel1,
`endif
   output logic        almost_full,
   output logic        empty,
   input  logic [1:0]  rd_num,
   output logic        rd_valid0,
   output logic [31:0] rd_pc0,
   output logic [31:0] rd_instr0,
   output logic        rd_valid1,
   output logic [31:0] rd_pc1,
   output logic [31:0] rd_instr1
);

   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

   // Storage is intentionally not reset; validity comes from count alone.
   logic [31:0] mem_pc    [DEPTH];
   logic [31:0] mem_instr [DEPTH];
`ifdef INST_FETCH_QUEUE_EXCP_EN
   logic [DEPTH-1:0] mem_adel;
`endif

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic [1:0]       wr_num;
   logic [1:0]       wr_acc;
   logic [1:0]       rd_cap;
   logic [1:0]       rd_eff;
   logic [PTR_W:0]   free;
   logic [PTR_W-1:0] rd_ptr1;
   logic [PTR_W-1:0] wr_ptr1;

   // ---------------- write / pop bookkeeping ----------------
   always_comb begin
      // 2'b10 is illegal and behaves as no write
      case (wr_en)
         2'b01:   wr_num = 2'd1;
         2'b11:   wr_num = 2'd2;
         default: wr_num = 2'd0;
      endcase

      // Acceptance uses the pre-pop count, so a pop in the same cycle
      // never makes room for that cycle's write. All-or-nothing.
      free   = DEPTH_C - count;
      wr_acc = (free >= (PTR_W+1)'(wr_num)) ? wr_num : 2'd0;

      // Only two read ports exist, so rd_num=3 caps at 2, then at count.
      rd_cap = (rd_num == 2'd3) ? 2'd2 : rd_num;
      if (count < (PTR_W+1)'(rd_cap))
         rd_eff = count[1:0];
      else
         rd_eff = rd_cap;

      rd_ptr1 = rd_ptr + ONE;
      wr_ptr1 = wr_ptr + ONE;
   end

   // ---------------- pointer / count state ----------------
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(wr_acc);
         rd_ptr <= rd_ptr + PTR_W'(rd_eff);
         count  <= count + (PTR_W+1)'(wr_acc) - (PTR_W+1)'(rd_eff);
      end
   end

   // ---------------- storage writes ----------------
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         if (wr_acc != 2'd0) begin
            mem_pc[wr_ptr]    <= wr_pc0;
            mem_instr[wr_ptr] <= wr_instr0;
         end
         if (wr_acc == 2'd2) begin
            mem_pc[wr_ptr1]    <= wr_pc1;
            mem_instr[wr_ptr1] <= wr_instr1;
         end
      end
   end

`ifdef INST_FETCH_QUEUE_EXCP_EN
   // Tags are small enough to clear outright on rst/flush.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         mem_adel <= '0;
      end else begin
         if (wr_acc != 2'd0) mem_adel[wr_ptr]  <= wr_adel0;
         if (wr_acc == 2'd2) mem_adel[wr_ptr1] <= wr_adel1;
      end
   end
`endif

   // ---------------- read view ----------------
   assign rd_valid0   = (count != '0);
   assign rd_valid1   = (count >= (PTR_W+1)'(2));
   assign rd_pc0      = rd_valid0 ? mem_pc[rd_ptr]     : 32'h0;
   assign rd_instr0   = rd_valid0 ? mem_instr[rd_ptr]  : 32'h0;
   assign rd_pc1      = rd_valid1 ? mem_pc[rd_ptr1]    : 32'h0;
   assign rd_instr1   = rd_valid1 ? mem_instr[rd_ptr1] : 32'h0;
`ifdef INST_FETCH_QUEUE_EXCP_EN
   assign rd_adel0    = rd_valid0 & mem_adel[rd_ptr];
   assign rd_adel1    = rd_valid1 & mem_adel[rd_ptr1];
`endif

   assign almost_full = (free < (PTR_W+1)'(2));
   assign empty       = (count == '0);

   // ---------------- protocol checks ----------------
   // A dropped write means fetch ignored almost_full; it is reported but
   // the queue stays consistent, so it does not stop simulation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (wr_en != 2'b10)
            else $error("inst_fetch_queue: illegal wr_en pattern 2'b10");
         if (!flush)
            assert (wr_acc == wr_num)
               else $warning("inst_fetch_queue: write dropped, queue full");
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [1:0]  wr_en, rd_num;
   logic [31:0] wr_pc0, wr_instr0, wr_pc1, wr_instr1;
   logic        almost_full, empty;
   logic        rd_valid0, rd_valid1;
   logic [31:0] rd_pc0, rd_instr0, rd_pc1, rd_instr1;
   logic        wr_adel0, wr_adel1;
`ifdef INST_FETCH_QUEUE_EXCP_EN
   logic        rd_adel0, rd_adel1;
`endif

   always #5 clk = ~clk;

   inst_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en),
      .wr_pc0(wr_pc0), .wr_instr0(wr_instr0),
      .wr_pc1(wr_pc1), .wr_instr1(wr_instr1),
`ifdef INST_FETCH_QUEUE_EXCP_EN
      .wr_adel0(wr_adel0), .wr_adel1(wr_adel1),
      .rd_adel0(rd_adel0), .rd_adel1(rd_adel1),
`endif
      .almost_full(almost_full), .empty(empty), .rd_num(rd_num),
      .rd_valid0(rd_valid0), .rd_pc0(rd_pc0), .rd_instr0(rd_instr0),
      .rd_valid1(rd_valid1), .rd_pc1(rd_pc1), .rd_instr1(rd_instr1)
   );

   // Reference model: a plain FIFO of entries, oldest at index 0.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } ent_t;
   ent_t q[$];

   int n_chk = 0;
   int n_err = 0;
   int unsigned seq_pc;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_all();
      int          sz;
      logic        v0, v1;
      logic [31:0] p0, i0, p1, i1;
      sz = q.size();
      v0 = (sz >= 1);
      v1 = (sz >= 2);
      p0 = 32'h0; i0 = 32'h0; p1 = 32'h0; i1 = 32'h0;
      if (v0) begin p0 = q[0].pc; i0 = q[0].instr; end
      if (v1) begin p1 = q[1].pc; i1 = q[1].instr; end
      chk("rd_valid0", 32'(rd_valid0), 32'(v0));
      chk("rd_pc0", rd_pc0, p0);
      chk("rd_instr0", rd_instr0, i0);
      chk("rd_valid1", 32'(rd_valid1), 32'(v1));
      chk("rd_pc1", rd_pc1, p1);
      chk("rd_instr1", rd_instr1, i1);
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("almost_full", 32'(almost_full), 32'((DEPTH - sz) < 2));
      chk("count", 32'(dut.count), 32'(sz));
`ifdef INST_FETCH_QUEUE_EXCP_EN
      chk("rd_adel0", 32'(rd_adel0), 32'(v0 ? q[0].adel : 1'b0));
      chk("rd_adel1", 32'(rd_adel1), 32'(v1 ? q[1].adel : 1'b0));
`endif
   endtask

   // Drive one cycle at the falling edge, advance the model, check after.
   task automatic step(input logic r, input logic f, input logic [1:0] we,
                       input logic [1:0] rn,
                       input logic [31:0] p0, input logic [31:0] i0,
                       input logic [31:0] p1, input logic [31:0] i1,
                       input logic a0, input logic a1);
      int wn, re;
      bit acc;
      rst = r; flush = f; wr_en = we; rd_num = rn;
      wr_pc0 = p0; wr_instr0 = i0; wr_pc1 = p1; wr_instr1 = i1;
      wr_adel0 = a0; wr_adel1 = a1;
      if (r || f) begin
         q.delete();
      end else begin
         wn  = (we == 2'b11) ? 2 : (we == 2'b01) ? 1 : 0;
         acc = ((DEPTH - q.size()) >= wn);
         re  = (rn == 2'd3) ? 2 : int'(rn);
         if (re > q.size()) re = q.size();
         repeat (re) void'(q.pop_front());
         if (acc && wn >= 1) q.push_back('{pc: p0, instr: i0, adel: a0});
         if (acc && wn == 2) q.push_back('{pc: p1, instr: i1, adel: a1});
      end
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   // Sequential-PC write helper with random instructions and tags.
   task automatic wr_seq(input logic [1:0] we, input logic [1:0] rn);
      logic [31:0] p0, p1;
      p0 = seq_pc;
      p1 = seq_pc + 32'd4;
      step(1'b0, 1'b0, we, rn, p0, $urandom, p1, $urandom,
           1'($urandom), 1'($urandom));
      seq_pc = seq_pc + ((we == 2'b11) ? 32'd8 : (we == 2'b01) ? 32'd4 : 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; wr_en = 2'b00; rd_num = 2'd0;
      wr_pc0 = '0; wr_instr0 = '0; wr_pc1 = '0; wr_instr1 = '0;
      wr_adel0 = 1'b0; wr_adel1 = 1'b0;
      @(negedge clk);

      // Reset then idle
      step(1'b1, 1'b0, 2'b00, 2'd0, 0, 0, 0, 0, 0, 0);
      step(1'b0, 1'b0, 2'b00, 2'd0, 0, 0, 0, 0, 0, 0);

      // First pair, no bypass: visible after the edge
      step(1'b0, 1'b0, 2'b11, 2'd0, 32'hBFC00000, 32'h24080001,
           32'hBFC00004, 32'h00000000, 1'b0, 1'b1);
      chk("boot_pc0", rd_pc0, 32'hBFC00000);
      chk("boot_instr0", rd_instr0, 32'h24080001);
      chk("boot_pc1", rd_pc1, 32'hBFC00004);

      // Fill to 15, dropped write, then drain two
      seq_pc = 32'hBFC00008;
      repeat (6) wr_seq(2'b11, 2'd0);
      wr_seq(2'b01, 2'd0);
      chk("fill_af", 32'(almost_full), 32'd1);
      step(1'b0, 1'b0, 2'b11, 2'd0, 32'hDEAD0000, 32'h1, 32'hDEAD0004, 32'h2, 0, 0);
      chk("drop_count", 32'(dut.count), 32'd15);
      step(1'b0, 1'b0, 2'b00, 2'd2, 0, 0, 0, 0, 0, 0);
      chk("drain_count", 32'(dut.count), 32'd13);
      chk("drain_af", 32'(almost_full), 32'd0);

      // Steady state: push 2 / pop 2 for 40 cycles across the wrap
      step(1'b0, 1'b1, 2'b00, 2'd0, 0, 0, 0, 0, 0, 0);
      seq_pc = 32'h80000000;
      for (int k = 0; k < 40; k++) begin
         wr_seq(2'b11, 2'd2);
         chk("seq_pc0", rd_pc0, 32'h80000000 + 32'(8 * k));
         chk("seq_pc1", rd_pc1, 32'h80000004 + 32'(8 * k));
      end

      // Flush with count=5, concurrent write and pop
      step(1'b0, 1'b1, 2'b00, 2'd0, 0, 0, 0, 0, 0, 0);
      wr_seq(2'b11, 2'd0);
      wr_seq(2'b11, 2'd0);
      wr_seq(2'b01, 2'd0);
      chk("pre_flush_count", 32'(dut.count), 32'd5);
      step(1'b0, 1'b1, 2'b11, 2'd2, 32'h1234, 32'h5678, 32'h1238, 32'h9ABC, 1, 1);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_wr_ptr", 32'(dut.wr_ptr), 32'd0);
      wr_seq(2'b11, 2'd0);
      chk("post_flush_rd_ptr", 32'(dut.rd_ptr), 32'd0);

      // Clamped pop: count=1, rd_num=2
      step(1'b0, 1'b0, 2'b00, 2'd1, 0, 0, 0, 0, 0, 0);
      chk("clamp_pre", 32'(dut.count), 32'd1);
      step(1'b0, 1'b0, 2'b00, 2'd2, 0, 0, 0, 0, 0, 0);
      chk("clamp_ptr_eq", 32'(dut.rd_ptr), 32'(dut.wr_ptr));
      chk("clamp_empty", 32'(empty), 32'd1);

      // Randomized traffic honouring almost_full, with rare flush / reset
      for (int k = 0; k < 400; k++) begin
         logic [1:0] we, rn;
         logic       f, r;
         int         sel;
         sel = $urandom_range(0, 2);
         we  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
         if (q.size() >= DEPTH - 1) we = (q.size() == DEPTH - 1) ? 2'b01 : 2'b00;
         rn = 2'($urandom_range(0, 3));
         f  = ($urandom_range(0, 29) == 0);
         r  = (k == 200);
         step(r, f, we, rn, $urandom, $urandom, $urandom, $urandom,
              1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
